stream_find_max: RTL
====================

Name: stream_find_max

Overview:
- Parametrised, sequential successor to the combinational three-input find_max.
- Accepts a stream of WIDTH-bit samples over a valid/ready handshake.
- Tracks the maximum value, the index of that value and the sample count across a frame.
- A frame ends after FRAME_LEN samples or on an early in_last. The registered result is then presented on a valid/ready output. The block sits between a sample producer and any consumer of per-frame peak statistics.

Parameters:
- WIDTH, 8: sample width in bits, must be >= 1.
- FRAME_LEN, 4: maximum number of samples per frame, must be >= 1.
- SIGNED, 0: 0 compares samples as unsigned; 1 compares them as two's complement.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  WIDTH  sample value.
- in_last  in  1  accepted sample is the last of its frame (early termination).
- out_valid  out  1  result registers hold a completed frame.
- out_ready  in  1  consumer takes the result this cycle.
- out_max  out  WIDTH  maximum sample of the frame.
- out_idx  out  IDX_W  zero-based position of the maximum, where IDX_W = max(1, clog2(FRAME_LEN)).
- out_count  out  CNT_W  samples in the frame (1..FRAME_LEN), where CNT_W = clog2(FRAME_LEN+1).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n is low: state=IDLE, out_valid=0, out_max=0, out_idx=0, out_count=0, and in_ready is forced 0.
  - A partially accumulated frame is discarded.
  - in_ready rises in the first cycle after rst_n deasserts.
- Accept: a sample is taken when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. An accept loads run_max=in_data, run_idx=0, cnt=1. If the frame ends on this sample, go to HOLD; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept, cnt increments. If in_data is strictly greater than run_max (per SIGNED), run_max=in_data and run_idx=cnt_before_increment.
  - HOLD: out_valid=1 and the outputs are stable. in_ready = out_ready.
    - If out_valid && out_ready && !in_valid: go to IDLE.
    - If out_valid && out_ready && in_valid: the sample is accepted as the first of the next frame (same load as from IDLE), giving zero-bubble back-to-back frames. The next state is HOLD if that sample ends its frame, otherwise ACCUM.
- Frame end: the accepted sample has in_last=1, or cnt reaches FRAME_LEN.
  - out_max, out_idx and out_count are registered from the updated running values, including the final sample.
  - out_valid asserts the cycle after the final sample is accepted (latency 1).
- Ties: the earliest index wins; an equal value never replaces run_max.
- Boundary cases:
  - in_last on the first sample gives out_count=1 and out_idx=0.
  - FRAME_LEN=1 means every sample is its own frame.
  - in_last on sample FRAME_LEN is equivalent to the count limit.
  - Counters never wrap past FRAME_LEN.
- Backpressure: with out_valid=1 and out_ready=0, all outputs hold and no input is consumed.
- in_data and in_last are ignored when not accepted.

Decomposition:
- Package stream_find_max_pkg holds:
  - the state enum {IDLE, ACCUM, HOLD};
  - a parametrised compare function gt(a, b, signed_mode).
- Sub-module max_cmp: a combinational strict greater-than of two WIDTH-bit values, selected by the SIGNED parameter. It is instantiated once and verified standalone against the old find_max vectors.

Test Plan:
1. WIDTH=3, FRAME_LEN=3, unsigned: samples 101, 100, 001 -> out_max=101, out_idx=0, out_count=3, out_valid one cycle after the third accept. Then samples 010, 011, 000 -> out_max=011, out_idx=1.
2. Tie plus early end: WIDTH=8, FRAME_LEN=4, samples 3, 6, 6 with in_last on the third -> out_max=6, out_idx=1, out_count=3.
3. Signed: WIDTH=3, SIGNED=1, samples 101(-3), 010(+2), 111(-1) -> out_max=010, out_idx=1. The same vectors with SIGNED=0 -> out_max=111, out_idx=2.
4. Backpressure and back-to-back:
   - Hold out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0, nothing consumed.
   - Then raise out_ready with in_valid=1 and in_data=9 -> result retired and 9 accepted in the same cycle. A following 4-sample frame 9, 2, 2, 1 gives out_max=9, out_idx=0.
5. Reset mid-frame: accept 2 of 4 samples, pulse rst_n low asynchronously (not clock-aligned) -> outputs zero immediately. The next full frame 1, 2, 3, 4 gives out_max=4, out_idx=3, out_count=4, with no residue from the discarded frame.
6. FRAME_LEN=1: a continuous stream 5, 7, 2 with out_ready=1 -> three results 5, 7, 2, each with out_idx=0 and out_count=1, and in_ready held high throughout.

Source files
------------

// File: rtl/stream_find_max_pkg.sv
// Shared types and the compare helper for the streaming frame-maximum tracker.
package stream_find_max_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  function automatic logic gt(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                              input int unsigned w, input logic signed_mode);
    logic [MAX_W-1:0] m;
    m = signed_mode ? (MAX_W'(1) << (w - 1)) : '0;
    return (a ^ m) > (b ^ m);
  endfunction

endpackage

// File: rtl/stream_find_max_cmp.sv
// Strict greater-than of two WIDTH-bit values, unsigned or two's complement.
module max_cmp
  import stream_find_max_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b
);

  assign a_gt_b = gt(MAX_W'(a), MAX_W'(b), WIDTH, SIGNED != 0);

endmodule

// File: rtl/stream_find_max.sv
// Per-frame maximum, index-of-maximum and sample count over a valid/ready stream.
module stream_find_max
  import stream_find_max_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int SIGNED    = 0,
  localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count
);

  state_t           state;
  logic [WIDTH-1:0] run_max, nxt_max;
  logic [IDX_W-1:0] run_idx, nxt_idx;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             acc, first, frame_end, in_gt;

  // While holding a result, a new sample is only taken as the old one retires.
  assign in_ready = rst_n && (state != HOLD || out_ready);
  assign acc      = in_valid && in_ready;
  assign first    = (state != ACCUM);

  max_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .a      (in_data),
    .b      (run_max),
    .a_gt_b (in_gt)
  );

  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    nxt_cnt = cnt + 1'b1;
    if (first) begin
      nxt_max = in_data;
      nxt_idx = '0;
      nxt_cnt = CNT_W'(1);
    end else if (in_gt) begin
      nxt_max = in_data;
      nxt_idx = IDX_W'(cnt);
    end
  end

  assign frame_end = in_last || (nxt_cnt == CNT_W'(FRAME_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_count <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      cnt       <= '0;
    end else if (acc) begin
      if (frame_end) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        out_max   <= nxt_max;
        out_idx   <= nxt_idx;
        out_count <= nxt_cnt;
      end else begin
        state     <= ACCUM;
        out_valid <= 1'b0;
        run_max   <= nxt_max;
        run_idx   <= nxt_idx;
        cnt       <= nxt_cnt;
      end
    end else if (state == HOLD && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule
